// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state enum, next-PC select encodings and reset PC default.
package fetch_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2,
        REDIR    = 2'd3
    } state_t;

    // Next-PC select. Encoding 2'b11 also selects the branch target.
    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BRA = 2'b01;
    localparam logic [1:0] SEL_RAA = 2'b10;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    // One-entry buffer for an instruction returned while decode is frozen.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc1;
    } hold_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational branch-select decode and next-PC target mux.
// Ports: pc, bs/ps/z/br_valid, bra/raa in; redirect, pc_inc, next_pc out.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [1:0]  bs,
    input  logic        ps,
    input  logic        z,
    input  logic        br_valid,
    input  logic [15:0] bra,
    input  logic [15:0] raa,
    output logic        redirect,
    output logic [15:0] pc_inc,
    output logic [15:0] next_pc
);

    logic [1:0] sel;

    always_comb begin
        // bs[1] forces the low bit to follow bs[0], so 11 is an
        // unconditional branch and 10 is a register jump.
        sel      = {bs[1], ((ps ^ z) | bs[1]) & bs[0]};
        pc_inc   = pc + 16'd1;
        next_pc  = pc_inc;
        unique case (sel)
            SEL_SEQ: next_pc = pc_inc;
            SEL_RAA: next_pc = raa;
            default: next_pc = bra;
        endcase
        redirect = br_valid && (sel != SEL_SEQ);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, imem request FSM, IR and hold buffer.
// Ports: clk/rst, branch inputs, stall, imem req/addr/ack/data, ir/ir_valid/pc1_out/flush.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bs,
    input  logic        ps,
    input  logic        z,
    input  logic        br_valid,
    input  logic [15:0] bra,
    input  logic [15:0] raa,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc1_out,
    output logic        flush
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] pc1_q, pc1_d;
    logic        flush_q, flush_d;
    logic        req_q, req_d;
    hold_t       hb_q, hb_d;
    logic        hb_valid_q, hb_valid_d;

    logic        redirect;
    logic [15:0] pc_inc;
    logic [15:0] next_pc;

    next_pc_sel u_sel (
        .pc       (pc_q),
        .bs       (bs),
        .ps       (ps),
        .z        (z),
        .br_valid (br_valid),
        .bra      (bra),
        .raa      (raa),
        .redirect (redirect),
        .pc_inc   (pc_inc),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc1_d      = pc1_q;
        hb_d       = hb_q;
        hb_valid_d = hb_valid_q;
        flush_d    = 1'b0;

        if (redirect) begin
            // Redirect wins over ack and stall; same-cycle ack data is dropped.
            pc_d       = next_pc;
            hb_d       = '0;
            hb_valid_d = 1'b0;
            ir_valid_d = 1'b0;
            flush_d    = 1'b1;
            state_d    = REDIR;
        end else begin
            unique case (state_q)
                RST_WAIT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            hb_d       = '{instr: imem_data, pc1: pc_inc};
                            hb_valid_d = 1'b1;
                            state_d    = HOLD;
                        end else begin
                            ir_d       = imem_data;
                            ir_valid_d = 1'b1;
                            pc1_d      = pc_inc;
                        end
                    end else if (!stall) begin
                        // Decode consumed the old word and nothing new arrived.
                        ir_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ir_d       = hb_q.instr;
                        pc1_d      = hb_q.pc1;
                        ir_valid_d = 1'b1;
                        hb_valid_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                REDIR: begin
                    state_d = FETCH;
                end
                default: begin
                    state_d = RST_WAIT;
                end
            endcase
        end

        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_WAIT;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc1_q      <= '0;
            flush_q    <= 1'b0;
            req_q      <= 1'b0;
            hb_q       <= '0;
            hb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc1_q      <= pc1_d;
            flush_q    <= flush_d;
            req_q      <= req_d;
            hb_q       <= hb_d;
            hb_valid_q <= hb_valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc1_out   = pc1_q;
    assign flush     = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl.
// Each vector drives one cycle of inputs and checks outputs after the edge.
module tb_fetch_ctrl;

    typedef struct {
        logic [1:0]  bs;
        logic        ps;
        logic        z;
        logic        bv;
        logic [15:0] bra;
        logic [15:0] raa;
        logic        st;
        logic        ack;
        logic [15:0] data;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic        e_v;
        logic [15:0] e_pc1;
        logic        e_fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bs;
    logic        ps, z, br_valid, stall, imem_ack;
    logic [15:0] bra, raa, imem_data;
    logic        imem_req, ir_valid, flush;
    logic [15:0] imem_addr, ir, pc1_out;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bs        (bs),
        .ps        (ps),
        .z         (z),
        .br_valid  (br_valid),
        .bra       (bra),
        .raa       (raa),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc1_out   (pc1_out),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req,
                           input logic [15:0] e_addr, input logic [15:0] e_ir,
                           input logic e_v, input logic [15:0] e_pc1,
                           input logic e_fl);
        chk({tag, ".req"},   {15'd0, imem_req}, {15'd0, e_req});
        chk({tag, ".addr"},  imem_addr, e_addr);
        chk({tag, ".ir"},    ir, e_ir);
        chk({tag, ".valid"}, {15'd0, ir_valid}, {15'd0, e_v});
        chk({tag, ".pc1"},   pc1_out, e_pc1);
        chk({tag, ".flush"}, {15'd0, flush}, {15'd0, e_fl});
    endtask

    function automatic vec_t mk(
        input logic [1:0] b, input logic p, input logic zz, input logic v,
        input logic [15:0] ba, input logic [15:0] ra, input logic s,
        input logic a, input logic [15:0] d,
        input logic er, input logic [15:0] ea, input logic [15:0] ei,
        input logic ev, input logic [15:0] ep, input logic ef);
        vec_t t;
        t.bs = b;   t.ps = p;   t.z = zz;  t.bv = v;
        t.bra = ba; t.raa = ra; t.st = s;  t.ack = a; t.data = d;
        t.e_req = er; t.e_addr = ea; t.e_ir = ei;
        t.e_v = ev;   t.e_pc1 = ep;  t.e_fl = ef;
        return t;
    endfunction

    task automatic idle();
        bs = 2'b00; ps = 1'b0; z = 1'b0; br_valid = 1'b0;
        bra = 16'h0; raa = 16'h0; stall = 1'b0;
        imem_ack = 1'b0; imem_data = 16'h0;
    endtask

    initial begin
        //      bs    ps z  bv bra      raa      st a  data       req addr     ir       v  pc1      fl
        // late ack in RST_WAIT is ignored
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hDEAD, 1,16'h0000,16'h0000,0,16'h0000,0));
        // sequential fetch, data = addr ^ A5A5
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A5, 1,16'h0001,16'hA5A5,1,16'h0001,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A4, 1,16'h0002,16'hA5A4,1,16'h0002,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A7, 1,16'h0003,16'hA5A7,1,16'h0003,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A6, 1,16'h0004,16'hA5A6,1,16'h0004,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A1, 1,16'h0005,16'hA5A1,1,16'h0005,0));
        // ack at addr 5 under stall -> HOLD for 3 stalled cycles
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,1,1,16'hA5A0, 0,16'h0006,16'hA5A1,1,16'h0005,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,1,0,16'h0000, 0,16'h0006,16'hA5A1,1,16'h0005,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,1,0,16'h0000, 0,16'h0006,16'hA5A1,1,16'h0005,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,16'h0006,16'hA5A0,1,16'h0006,0));
        // stall without ack in FETCH: everything holds
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,1,0,16'h0000, 1,16'h0006,16'hA5A0,1,16'h0006,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5A3, 1,16'h0007,16'hA5A3,1,16'h0007,0));
        // taken branch with concurrent ack
        vq.push_back(mk(2'b01,0,1,1,16'h0040,16'h0000,0,1,16'hA5A2, 0,16'h0040,16'hA5A3,0,16'h0007,1));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,16'h0040,16'hA5A3,0,16'h0007,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA5E5, 1,16'h0041,16'hA5E5,1,16'h0041,0));
        // not taken, and taken-but-invalid
        vq.push_back(mk(2'b01,0,0,1,16'h0040,16'h0000,0,1,16'hA5E4, 1,16'h0042,16'hA5E4,1,16'h0042,0));
        vq.push_back(mk(2'b01,0,1,0,16'h0040,16'h0000,0,1,16'hA5E7, 1,16'h0043,16'hA5E7,1,16'h0043,0));
        // jump, then a second redirect while in REDIR (bs=11 -> bra)
        vq.push_back(mk(2'b10,0,0,1,16'h0000,16'h1234,0,0,16'h0000, 0,16'h1234,16'hA5E7,0,16'h0043,1));
        vq.push_back(mk(2'b11,0,0,1,16'hFFFF,16'h0000,0,0,16'h0000, 0,16'hFFFF,16'hA5E7,0,16'h0043,1));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,16'hFFFF,16'hA5E7,0,16'h0043,0));
        // wrap from FFFF
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'h5A5A, 1,16'h0000,16'h5A5A,1,16'h0000,0));
        // redirect while HOLD and stalled clears the buffer
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,1,1,16'hA5A5, 0,16'h0001,16'h5A5A,1,16'h0000,0));
        vq.push_back(mk(2'b10,0,0,1,16'h0000,16'h0100,1,0,16'h0000, 0,16'h0100,16'h5A5A,0,16'h0000,1));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,16'h0100,16'h5A5A,0,16'h0000,0));
        vq.push_back(mk(2'b00,0,0,0,16'h0000,16'h0000,0,1,16'hA4A5, 1,16'h0101,16'hA4A5,1,16'h0101,0));

        rst = 1'b1;
        idle();
        #12;
        chk_all("reset", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("rst_wait", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);

        foreach (vq[i]) begin
            bs = vq[i].bs;   ps = vq[i].ps;   z = vq[i].z;
            br_valid = vq[i].bv;
            bra = vq[i].bra; raa = vq[i].raa; stall = vq[i].st;
            imem_ack = vq[i].ack; imem_data = vq[i].data;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr,
                    vq[i].e_ir, vq[i].e_v, vq[i].e_pc1, vq[i].e_fl);
        end

        // async reset between edges while fetching at 0101
        idle();
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_data = 16'hDEAD;
        #1;
        chk_all("rel_rst", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        @(posedge clk);
        #1;
        chk_all("late_ack", 1, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        imem_data = 16'hA5A5;
        @(posedge clk);
        #1;
        chk_all("refetch", 1, 16'h0001, 16'hA5A5, 1, 16'h0001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
